sqrt_arbiter: RTL

- Shares one multi-cycle floating-point sqrt unit among NREQ requesters using round-robin arbitration.
- Accepts an IEEE-754 single operand from each requester and sequences the unit's start/done handshake.
- Routes each result back to its owner, with a timeout guard and a negative-operand trap.
- Sits between the integer-clock-domain clients and the sqrt datapath; all of its logic runs on int_clk.

---
 rtl/sqrt_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sqrt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_arbiter
// Brief    : Round-robin sharing of one multi-cycle FP sqrt unit among NREQ
//            requesters. Optional macro SQRT_ARB_BYPASS_EN answers +0, -0 and
//            1.0 directly without using the unit.
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  int_clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_operand,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  resp_err,
    output logic                  busy,
    output logic [WIDTH-1:0]      sq_A,
    output logic                  sq_start,
    input  logic                  sq_done,
    input  logic [WIDTH-1:0]      sq_Out
);
    localparam int               c_IW      = $clog2(NREQ);
    localparam logic [WIDTH-1:0] c_QNAN    = WIDTH'(32'h7fc0_0000);
    localparam logic [15:0]      c_TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [NREQ-1:0]  c_ONE     = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [c_IW-1:0]   r_last_grant;
    logic [c_IW-1:0]   r_grant;
    logic [15:0]       r_count;
    logic [NREQ-1:0]   r_req_ready;
    logic [NREQ-1:0]   r_resp_valid;
    logic [WIDTH-1:0]  r_resp_data;
    logic              r_resp_err;
    logic              r_busy;
    logic [WIDTH-1:0]  r_sq_A;
    logic              r_sq_start;

    logic              w_found;
    logic [c_IW-1:0]   w_idx;
    logic [c_IW-1:0]   w_cand;
    logic [WIDTH-1:0]  w_op;
    logic              w_neg;
    logic              w_bypass;
    logic              w_timeout;

    // Scan upward from the slot after the last grant, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = c_IW'((int'(r_last_grant) + k) % NREQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign w_op      = req_operand[w_idx*WIDTH +: WIDTH];
    assign w_neg     = w_op[WIDTH-1] && (w_op[WIDTH-2:0] != '0);
    assign w_timeout = (r_count == c_TO_LAST);

`ifdef SQRT_ARB_BYPASS_EN
    assign w_bypass  = (w_op[WIDTH-2:0] == '0) || (w_op == WIDTH'(32'h3f80_0000));
`else
    assign w_bypass  = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = (w_neg || w_bypass) ? S_RESP : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (sq_done || w_timeout) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge int_clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Outputs are registered: each state's action is visible the cycle after it.
    always_ff @(posedge int_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= c_IW'(NREQ - 1);
            r_grant      <= '0;
            r_count      <= '0;
            r_req_ready  <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
            r_sq_A       <= '0;
            r_sq_start   <= 1'b0;
        end else begin
            r_req_ready  <= '0;
            r_resp_valid <= '0;
            r_sq_start   <= 1'b0;
            r_busy       <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant     <= w_idx;
                        r_req_ready <= c_ONE << w_idx;
                        if (w_neg) begin
                            r_resp_data <= c_QNAN;
                            r_resp_err  <= 1'b1;
                        end else if (w_bypass) begin
                            r_resp_data <= w_op;
                            r_resp_err  <= 1'b0;
                        end else begin
                            r_sq_A      <= w_op;
                        end
                    end
                end
                S_ISSUE: begin
                    r_sq_start <= 1'b1;
                    r_count    <= '0;
                end
                S_WAIT: begin
                    if (sq_done) begin
                        r_resp_data <= sq_Out;
                        r_resp_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_resp_data <= c_QNAN;
                        r_resp_err  <= 1'b1;
                    end else begin
                        r_count     <= r_count + 16'd1;
                    end
                end
                S_RESP: begin
                    r_resp_valid <= c_ONE << r_grant;
                    r_last_grant <= r_grant;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign busy       = r_busy;
    assign sq_A       = r_sq_A;
    assign sq_start   = r_sq_start;

endmodule
`default_nettype wire
